lshif_pwr_seq: RTL and testbench
================================

Name: lshif_pwr_seq

Overview:
- Synchronous sequencer for a switchable low-voltage domain whose outputs cross into the 3.3V domain through lshifup level-shifter cells.
- Drives the domain power switch and the active-low isolation clamp in front of the level shifters.
- Isolation is released only after power-good has been stable long enough; on power-down, isolation is asserted before power is removed.
- Sits in the always-on 3.3V domain, between the system power manager (REQ/ACK) and the header switch and clamp cells.

Parameters:
- PG_TIMEOUT, 64: max cycles from PWR_EN rise to PG rise before a fault is declared; must be >= 1.
- SETTLE_CYC, 8: consecutive cycles PG must stay high before isolation is released; must be >= 1.
- ISO_CYC, 4: cycles between isolation assertion and PWR_EN fall; must be >= 1.
- CNT_W, $clog2(max(PG_TIMEOUT,SETTLE_CYC,ISO_CYC)+1): timer width; derived, not overridden.

Ports:
- CLK  input  1  single clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- REQ  input  1  level request: 1 = domain on, 0 = domain off.
- PG  input  1  power-good from the switch; already synchronised externally.
- PWR_EN  output  1  power-switch enable.
- ISO_N  output  1  isolation control, active low; 0 = level-shifter inputs clamped.
- ACK  output  1  high only while the domain is on and isolation is released.
- ERR  output  1  sticky fault flag; cleared only via FAULT->OFF or RST.

Behaviour:
- All outputs are registered and decoded from the state.
- RST sampled high at an edge forces state OFF with PWR_EN=0, ISO_N=0, ACK=0, ERR=0, timer=0. This applies mid-sequence as well: power is cut without isolation delay, by design.
- States and outputs (PWR_EN/ISO_N/ACK/ERR):
  - OFF: 0/0/0/0
  - PWR_UP: 1/0/0/0
  - SETTLE: 1/0/0/0
  - ON: 1/1/1/0
  - ISO: 1/0/0/0
  - PWR_DN: 0/0/0/0
  - FAULT: 0/0/0/1
- Transitions (evaluated at each edge, priority in the order listed):
  - OFF: REQ=1 -> PWR_UP, timer loaded with PG_TIMEOUT-1.
  - PWR_UP:
    - REQ=0 -> PWR_DN (abort; isolation was never released).
    - PG=1 -> SETTLE, timer loaded with SETTLE_CYC-1.
    - timer==0 -> FAULT.
    - otherwise timer decrements.
  - SETTLE:
    - REQ=0 -> PWR_DN.
    - PG=0 -> PWR_UP, timer reloaded with PG_TIMEOUT-1.
    - timer==0 -> ON.
    - otherwise timer decrements.
  - ON:
    - PG=0 -> FAULT (unexpected brown-out; clamp next edge).
    - REQ=0 -> ISO, timer loaded with ISO_CYC-1.
  - ISO: timer==0 -> PWR_DN; otherwise decrement. REQ is ignored; power-down always completes.
  - PWR_DN: PG=0 -> OFF. REQ is ignored until OFF.
  - FAULT: REQ=0 -> OFF; ERR clears on that edge.
- Latency (REQ rise sampled at edge 0, PG already high at edge 1):
  - PWR_EN rises at edge 1.
  - ISO_N and ACK rise at edge 1+SETTLE_CYC+1.
- ISO_N is never 1 while PWR_EN is 0, in any state or cycle.
- ISO_N falls at least ISO_CYC cycles before PWR_EN on a normal power-down.
- Simultaneous REQ=0 and PG=0 in ON -> FAULT (PG wins).
- PG may rise in the same cycle PWR_EN rises; it is sampled from the next edge onward.

Decomposition:
- Package lshif_pwr_pkg holds:
  - state enum lshif_state_e with the 7 states, 3-bit encoding;
  - per-state output-decode constants.
- Sub-module lshif_seq_timer: loadable down-counter with inputs CLK, RST, load, load_val[CNT_W], dec; output zero. The FSM instantiates it once, shared by all three delays.

Test Plan (PG_TIMEOUT=8, SETTLE_CYC=3, ISO_CYC=2):
- Normal power-up: REQ=1 at edge 0, PG=1 from edge 2 -> PWR_EN=1 at edge 1; ISO_N=1 and ACK=1 at edge 6; ERR=0 throughout.
- Normal power-down from ON: REQ=0 at edge n -> ISO_N=0 and ACK=0 at n+1; PWR_EN=0 at n+3; OFF one edge after PG falls.
- PG timeout: REQ=1, PG held 0 -> PWR_EN high for 8 cycles, then PWR_EN=0 and ERR=1. ERR stays 1 while REQ=1; REQ=0 -> ERR=0 next edge, state OFF.
- SETTLE glitch: PG drops for 1 cycle mid-SETTLE -> returns to PWR_UP. ISO_N stays 0; release occurs SETTLE_CYC cycles after PG restabilises.
- Brown-out in ON: PG=0 while REQ=1 -> next edge ISO_N=0, PWR_EN=0, ACK=0, ERR=1.
- Abort and reset: REQ drops in SETTLE -> PWR_DN with no ISO_N pulse. RST asserted in ON -> all outputs 0 at the next edge.

Source files
------------

// File: rtl/lshif_pwr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lshif_pwr_pkg
//  Description : Shared types and output-decode constants for the lshifup
//                domain power sequencer (state encoding, per-state outputs).
//  Revision    : 1.0 - initial release
// ============================================================================
package lshif_pwr_pkg;

    // Sequencer states, explicit 3-bit encoding (code 7 is unused).
    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_PWR_UP = 3'd1,
        ST_SETTLE = 3'd2,
        ST_ON     = 3'd3,
        ST_ISO    = 3'd4,
        ST_PWR_DN = 3'd5,
        ST_FAULT  = 3'd6
    } lshif_state_e;

    // Output bundle, one bit per sequencer output.
    typedef struct packed {
        logic pwr_en;   // header switch enable
        logic iso_n;    // clamp control, 0 = level-shifter inputs clamped
        logic ack;      // domain on and usable
        logic err;      // sticky fault indication
    } lshif_out_t;

    // Per-state output values, packed as {pwr_en, iso_n, ack, err}.
    localparam lshif_out_t C_OUT_OFF    = 4'b0000;
    localparam lshif_out_t C_OUT_PWR_UP = 4'b1000;
    localparam lshif_out_t C_OUT_SETTLE = 4'b1000;
    localparam lshif_out_t C_OUT_ON     = 4'b1110;
    localparam lshif_out_t C_OUT_ISO    = 4'b1000;
    localparam lshif_out_t C_OUT_PWR_DN = 4'b0000;
    localparam lshif_out_t C_OUT_FAULT  = 4'b0001;

    // Output decode for a state. The only state with iso_n=1 also has
    // pwr_en=1, so the clamp can never be open on an unpowered domain.
    function automatic lshif_out_t state_outputs(input lshif_state_e st);
        lshif_out_t o;
        o = C_OUT_OFF;
        case (st)
            ST_OFF:    o = C_OUT_OFF;
            ST_PWR_UP: o = C_OUT_PWR_UP;
            ST_SETTLE: o = C_OUT_SETTLE;
            ST_ON:     o = C_OUT_ON;
            ST_ISO:    o = C_OUT_ISO;
            ST_PWR_DN: o = C_OUT_PWR_DN;
            ST_FAULT:  o = C_OUT_FAULT;
            default:   o = C_OUT_OFF;
        endcase
        return o;
    endfunction

    // Largest of three delay parameters; sizes the shared timer.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lshif_seq_timer.sv
`default_nettype none
// ============================================================================
//  Module      : lshif_seq_timer
//  Description : Loadable down-counter shared by the sequencer for the
//                power-good timeout, settle and isolation delays.
//  Revision    : 1.0 - initial release
// ============================================================================
module lshif_seq_timer #(
    parameter int CNT_W = 7
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load has priority over decrement; the count saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register, cleared by synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/lshif_pwr_seq.sv
`default_nettype none
// ============================================================================
//  Module      : lshif_pwr_seq
//  Description : Power/isolation sequencer for a switchable low-voltage
//                domain feeding lshifup level shifters. Enables the header
//                switch, waits for stable power-good, then opens the clamp;
//                on power-down closes the clamp before removing power.
//  Revision    : 1.0 - initial release
// ============================================================================
module lshif_pwr_seq
    import lshif_pwr_pkg::*;
#(
    parameter int PG_TIMEOUT = 64,
    parameter int SETTLE_CYC = 8,
    parameter int ISO_CYC    = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic REQ,
    input  logic PG,
    output logic PWR_EN,
    output logic ISO_N,
    output logic ACK,
    output logic ERR
);

    // Timer width covers the longest of the three delays.
    localparam int CNT_W = $clog2(max3(PG_TIMEOUT, SETTLE_CYC, ISO_CYC) + 1);

    // The timer counts load_val..0 inclusive, so each delay loads N-1.
    localparam logic [CNT_W-1:0] C_PG_LOAD     = CNT_W'(PG_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] C_ISO_LOAD    = CNT_W'(ISO_CYC - 1);

    lshif_state_e     state_q;
    lshif_state_e     state_d;
    lshif_out_t       out_q;

    logic             w_tmr_load;
    logic [CNT_W-1:0] w_tmr_val;
    logic             w_tmr_dec;
    logic             w_tmr_zero;

    lshif_seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .CLK      (CLK),
        .RST      (RST),
        .load     (w_tmr_load),
        .load_val (w_tmr_val),
        .dec      (w_tmr_dec),
        .zero     (w_tmr_zero)
    );

    // Next-state and timer control; branch order within a state is priority.
    always_comb begin
        state_d    = state_q;
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        w_tmr_dec  = 1'b0;
        case (state_q)
            ST_OFF: begin
                if (REQ) begin
                    state_d    = ST_PWR_UP;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = C_PG_LOAD;
                end
            end
            ST_PWR_UP: begin
                // Abort needs no isolation phase: the clamp never opened.
                if (!REQ) begin
                    state_d = ST_PWR_DN;
                end else if (PG) begin
                    state_d    = ST_SETTLE;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = C_SETTLE_LOAD;
                end else if (w_tmr_zero) begin
                    state_d = ST_FAULT;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (!REQ) begin
                    state_d = ST_PWR_DN;
                end else if (!PG) begin
                    // Power-good glitch: restart the whole ramp window.
                    state_d    = ST_PWR_UP;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = C_PG_LOAD;
                end else if (w_tmr_zero) begin
                    state_d = ST_ON;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            ST_ON: begin
                // Brown-out outranks a simultaneous power-down request so
                // the clamp closes on the very next edge.
                if (!PG) begin
                    state_d = ST_FAULT;
                end else if (!REQ) begin
                    state_d    = ST_ISO;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = C_ISO_LOAD;
                end
            end
            ST_ISO: begin
                // Once started, power-down runs to completion regardless of REQ.
                if (w_tmr_zero) begin
                    state_d = ST_PWR_DN;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            ST_PWR_DN: begin
                if (!PG) begin
                    state_d = ST_OFF;
                end
            end
            ST_FAULT: begin
                if (!REQ) begin
                    state_d = ST_OFF;
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase
    end

    // State register; reset cuts power immediately without isolation delay.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    // Output register decoded from the next state, so outputs change on the
    // same edge as the state and are glitch-free toward the switch cells.
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_q <= C_OUT_OFF;
        end else begin
            out_q <= state_outputs(state_d);
        end
    end

    assign PWR_EN = out_q.pwr_en;
    assign ISO_N  = out_q.iso_n;
    assign ACK    = out_q.ack;
    assign ERR    = out_q.err;

endmodule
`default_nettype wire

// File: tb/tb_lshif_pwr_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lshif_pwr_seq
//  Description : Self-checking bench for lshif_pwr_seq with a cycle-level
//                reference model feeding an expected-output scoreboard, plus
//                directed latency measurements.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lshif_pwr_seq;

    localparam int PG_TIMEOUT = 8;
    localparam int SETTLE_CYC = 3;
    localparam int ISO_CYC    = 2;

    localparam int M_OFF = 0, M_UP = 1, M_SET = 2, M_ON = 3,
                   M_ISO = 4, M_DN = 5, M_FLT = 6;

    logic CLK, RST, REQ, PG;
    logic PWR_EN, ISO_N, ACK, ERR;

    int   n_checks = 0;
    int   n_errors = 0;
    string phase = "reset";

    logic [3:0] exp_q[$];
    int   m_st  = M_OFF;
    int   m_cnt = 0;

    lshif_pwr_seq #(
        .PG_TIMEOUT (PG_TIMEOUT),
        .SETTLE_CYC (SETTLE_CYC),
        .ISO_CYC    (ISO_CYC)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .REQ    (REQ),
        .PG     (PG),
        .PWR_EN (PWR_EN),
        .ISO_N  (ISO_N),
        .ACK    (ACK),
        .ERR    (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Expected {PWR_EN, ISO_N, ACK, ERR} for each model state.
    function automatic logic [3:0] model_outs(input int st);
        case (st)
            M_UP, M_SET, M_ISO: return 4'b1000;
            M_ON:               return 4'b1110;
            M_FLT:              return 4'b0001;
            default:            return 4'b0000;
        endcase
    endfunction

    // Reference model: m_cnt counts cycles already spent in a timed state.
    always @(posedge CLK) begin
        if (RST) begin
            m_st  = M_OFF;
            m_cnt = 0;
        end else begin
            case (m_st)
                M_OFF: if (REQ) begin m_st = M_UP; m_cnt = 0; end
                M_UP: begin
                    if (!REQ)                          m_st = M_DN;
                    else if (PG)                       begin m_st = M_SET; m_cnt = 0; end
                    else if (m_cnt == PG_TIMEOUT - 1)  m_st = M_FLT;
                    else                               m_cnt++;
                end
                M_SET: begin
                    if (!REQ)                          m_st = M_DN;
                    else if (!PG)                      begin m_st = M_UP; m_cnt = 0; end
                    else if (m_cnt == SETTLE_CYC - 1)  m_st = M_ON;
                    else                               m_cnt++;
                end
                M_ON: begin
                    if (!PG)                           m_st = M_FLT;
                    else if (!REQ)                     begin m_st = M_ISO; m_cnt = 0; end
                end
                M_ISO: begin
                    if (m_cnt == ISO_CYC - 1)          m_st = M_DN;
                    else                               m_cnt++;
                end
                M_DN:  if (!PG)  m_st = M_OFF;
                M_FLT: if (!REQ) m_st = M_OFF;
                default: m_st = M_OFF;
            endcase
        end
        exp_q.push_back(model_outs(m_st));
    end

    // Scoreboard compare and clamp-safety invariant, sampled mid-cycle.
    always @(negedge CLK) begin
        logic [3:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq({"outs_", phase}, {28'd0, PWR_EN, ISO_N, ACK, ERR}, {28'd0, e});
            check_eq({"iso_safe_", phase}, {31'd0, ISO_N & ~PWR_EN}, 32'd0);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic power_up();
        REQ = 1'b1;
        tick();
        PG = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (ACK) break;
            tick();
        end
        check_eq("reach_on", {31'd0, ACK}, 32'd1);
    endtask

    task automatic power_down();
        REQ = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) begin
            if (!PWR_EN) break;
            tick();
        end
        PG = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int n;
        RST = 1'b1; REQ = 1'b0; PG = 1'b0;
        repeat (3) tick();
        check_eq("reset_outs", {28'd0, PWR_EN, ISO_N, ACK, ERR}, 32'd0);
        RST = 1'b0;
        tick();

        // Normal power-up: PG present from the first PWR_UP edge.
        phase = "up";
        REQ = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            if (n == 1) begin
                check_eq("pwr_en_edge1", {31'd0, PWR_EN}, 32'd1);
                PG = 1'b1;
            end
            if (ISO_N) break;
        end
        check_eq("up_latency", n, SETTLE_CYC + 2);
        repeat (3) tick();

        // Normal power-down: clamp closes ISO_CYC cycles before power drops.
        phase = "down";
        REQ = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            if (n == 1) check_eq("iso_first", {31'd0, ISO_N}, 32'd0);
            if (!PWR_EN) break;
        end
        check_eq("iso_to_pwr", n, ISO_CYC + 1);
        PG = 1'b0;
        repeat (2) tick();

        // PG timeout.
        phase = "timeout";
        REQ = 1'b1;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (PWR_EN) n++;
            if (ERR) break;
        end
        check_eq("timeout_len", n, PG_TIMEOUT);
        repeat (4) tick();
        check_eq("err_sticky", {31'd0, ERR}, 32'd1);
        REQ = 1'b0;
        tick();
        check_eq("err_clear", {31'd0, ERR}, 32'd0);
        tick();

        // One-cycle PG glitch during SETTLE.
        phase = "glitch";
        REQ = 1'b1;
        tick();
        PG = 1'b1;
        tick();
        tick();
        PG = 1'b0;
        tick();
        PG = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            if (ISO_N) break;
        end
        check_eq("glitch_release", n, SETTLE_CYC + 1);
        power_down();

        // Brown-out in ON, then PG-wins-over-REQ case.
        phase = "brownout";
        power_up();
        PG = 1'b0;
        tick();
        check_eq("brownout", {28'd0, PWR_EN, ISO_N, ACK, ERR}, 32'h1);
        REQ = 1'b0;
        tick();
        check_eq("fault_exit", {28'd0, PWR_EN, ISO_N, ACK, ERR}, 32'h0);
        phase = "pg_wins";
        power_up();
        REQ = 1'b0;
        PG  = 1'b0;
        tick();
        check_eq("pg_wins", {28'd0, PWR_EN, ISO_N, ACK, ERR}, 32'h1);
        tick();

        // Abort during SETTLE.
        phase = "abort";
        REQ = 1'b1;
        tick();
        PG = 1'b1;
        tick();
        REQ = 1'b0;
        tick();
        check_eq("abort", {28'd0, PWR_EN, ISO_N, ACK, ERR}, 32'h0);
        PG = 1'b0;
        tick();

        // Reset while ON.
        phase = "rst_on";
        power_up();
        RST = 1'b1;
        tick();
        check_eq("rst_on", {28'd0, PWR_EN, ISO_N, ACK, ERR}, 32'h0);
        RST = 1'b0;
        REQ = 1'b0;
        PG  = 1'b0;
        tick();

        // Random REQ/PG activity with a loosely realistic PG.
        phase = "random";
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(7, 0) == 0) REQ = ~REQ;
            if ($urandom_range(9, 0) == 0) PG = ~PWR_EN;
            else                           PG = PWR_EN;
            RST = ($urandom_range(63, 0) == 0);
            tick();
        end
        RST = 1'b0;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
